// File: rtl/smg_decode_module.sv
// smg_decode_module: samples a multiplexed active-low 7-segment bus and decodes each stable digit to a hex nibble.
// Optional macro SMG_DECODE_ERR_CNT_EN builds a saturating error counter on Err_Count; otherwise Err_Count is 0.
module smg_decode_module #(
    parameter int DIGITS     = 6,
    parameter int STABLE_CYC = 4
) (
    input  logic                CLK,
    input  logic                RSTn,
    input  logic [7:0]          SMG_Data,
    input  logic [DIGITS-1:0]   Scan_Sig,
    output logic [4*DIGITS-1:0] Number_Data,
    output logic [DIGITS-1:0]   Digit_Valid,
    output logic [DIGITS-1:0]   Digit_DP,
    output logic                Update,
    output logic                Pattern_Err,
    output logic [7:0]          Err_Count
);

    localparam int              SW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [7:0]      STABLE_C = 8'(STABLE_CYC);
    localparam logic [DIGITS-1:0] SCAN_OFF = '1;

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    typedef struct packed {
        logic       known;
        logic       blank;
        logic [3:0] nib;
    } seg_dec_t;

    function automatic seg_dec_t decode_seg(input logic [6:0] seg);
        seg_dec_t d;
        d = '{known: 1'b1, blank: 1'b0, nib: 4'h0};
        case (seg)
            7'h40: d.nib = 4'h0;
            7'h79: d.nib = 4'h1;
            7'h24: d.nib = 4'h2;
            7'h30: d.nib = 4'h3;
            7'h19: d.nib = 4'h4;
            7'h12: d.nib = 4'h5;
            7'h02: d.nib = 4'h6;
            7'h78: d.nib = 4'h7;
            7'h00: d.nib = 4'h8;
            7'h10: d.nib = 4'h9;
            7'h08: d.nib = 4'hA;
            7'h03: d.nib = 4'hB;
            7'h46: d.nib = 4'hC;
            7'h21: d.nib = 4'hD;
            7'h06: d.nib = 4'hE;
            7'h0E: d.nib = 4'hF;
            7'h7F: begin
                d.known = 1'b0;
                d.blank = 1'b1;
            end
            default: d.known = 1'b0;
        endcase
        return d;
    endfunction

    logic [7:0]        r_smg, last_smg;
    logic [DIGITS-1:0] r_scan, last_scan;
    state_t            state, state_nxt;
    logic [7:0]        cnt, cnt_nxt, cnt_step;
    logic              scan_off, changed, commit, one_hot, err_evt;
    logic [DIGITS-1:0] scan_low;
    logic [SW-1:0]     sel;
    seg_dec_t          dec;
    logic [3:0]        new_nib;
    logic              new_valid, new_dp, dig_chg;

    // Input stage plus a one-cycle-older copy used to detect a change on the bus.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_smg     <= 8'hFF;
            r_scan    <= SCAN_OFF;
            last_smg  <= 8'hFF;
            last_scan <= SCAN_OFF;
        end else begin
            // NOTE: non-blocking, so last_* captures the pre-edge r_* regardless of statement order.
            r_smg     <= SMG_Data;
            r_scan    <= Scan_Sig;
            last_smg  <= r_smg;
            last_scan <= r_scan;
        end
    end

    assign scan_off = (r_scan == SCAN_OFF);
    assign changed  = ({r_scan, r_smg} != {last_scan, last_smg});
    assign cnt_step = (state == SETTLE && !changed) ? cnt + 8'd1 : 8'd1;

    // FSM state register
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // FSM next state: a new or changed pair restarts at 1; a stable pair counts up to STABLE_CYC.
    always_comb begin
        // NOTE: defaults first so every path assigns every output (no latch).
        state_nxt = state;
        cnt_nxt   = cnt;
        if (scan_off) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else if (!(state == HOLD && !changed)) begin
            cnt_nxt   = cnt_step;
            state_nxt = (cnt_step == STABLE_C) ? HOLD : SETTLE;
        end
    end

    // FSM output: commit on the edge where the count reaches STABLE_CYC.
    always_comb begin
        commit = 1'b0;
        unique case (state)
            IDLE, SETTLE: commit = !scan_off && (cnt_step == STABLE_C);
            HOLD:         commit = !scan_off && changed && (cnt_step == STABLE_C);
            default:      commit = 1'b0;
        endcase
    end

    assign scan_low = ~r_scan;
    assign one_hot  = (scan_low != '0) && ((scan_low & (scan_low - DIGITS'(1))) == '0);
    assign dec      = decode_seg(r_smg[6:0]);
    assign err_evt  = commit && (!one_hot || (!dec.known && !dec.blank));

    always_comb begin
        sel = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!r_scan[i]) sel = SW'(i);
        end
    end

    // Blank and unknown codes both invalidate the digit but keep its nibble and DP.
    always_comb begin
        new_nib   = Number_Data[{sel, 2'b00} +: 4];
        new_valid = 1'b0;
        new_dp    = Digit_DP[sel];
        if (dec.known) begin
            new_nib   = dec.nib;
            new_valid = 1'b1;
            new_dp    = ~r_smg[7];
        end
        dig_chg = (new_nib != Number_Data[{sel, 2'b00} +: 4]) ||
                  (new_valid != Digit_Valid[sel]) ||
                  (new_dp != Digit_DP[sel]);
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            // NOTE: the per-digit store is ordinary flops, not a RAM, so it takes the reset too.
            Number_Data <= '0;
            Digit_Valid <= '0;
            Digit_DP    <= '0;
            Update      <= 1'b0;
            Pattern_Err <= 1'b0;
        end else begin
            Update <= commit && one_hot && dig_chg;
            if (err_evt) Pattern_Err <= 1'b1;
            if (commit && one_hot) begin
                Number_Data[{sel, 2'b00} +: 4] <= new_nib;
                Digit_Valid[sel]               <= new_valid;
                Digit_DP[sel]                  <= new_dp;
            end
        end
    end

`ifdef SMG_DECODE_ERR_CNT_EN
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            Err_Count <= 8'h00;
        end else if (err_evt && Err_Count != 8'hFF) begin
            Err_Count <= Err_Count + 8'd1;
        end
    end
`else
    assign Err_Count = 8'h00;
`endif

endmodule

// File: tb/tb_smg_decode_module.sv
// Scoreboard bench for smg_decode_module (DIGITS=6, STABLE_CYC=4): directed vectors with hand-computed results.
module tb_smg_decode_module;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic [7:0]  SMG_Data;
    logic [5:0]  Scan_Sig;
    logic [23:0] Number_Data;
    logic [5:0]  Digit_Valid;
    logic [5:0]  Digit_DP;
    logic        Update;
    logic        Pattern_Err;
    logic [7:0]  Err_Count;

    smg_decode_module #(.DIGITS(6), .STABLE_CYC(4)) dut (
        .CLK(CLK), .RSTn(RSTn), .SMG_Data(SMG_Data), .Scan_Sig(Scan_Sig),
        .Number_Data(Number_Data), .Digit_Valid(Digit_Valid), .Digit_DP(Digit_DP),
        .Update(Update), .Pattern_Err(Pattern_Err), .Err_Count(Err_Count)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [23:0] num;
        logic [5:0]  valid;
        logic [5:0]  dp;
    } snap_t;

    snap_t       exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          updates_seen = 0;
    int          updates_exp = 0;
    int          err_events = 0;
    logic [23:0] m_num = '0;
    logic [5:0]  m_valid = '0;
    logic [5:0]  m_dp = '0;
    logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_errcnt();
`ifdef SMG_DECODE_ERR_CNT_EN
        return (err_events > 255) ? 8'hFF : 8'(err_events);
`else
        return 8'h00;
`endif
    endfunction

    // Record the digit's expected value; an Update is expected only if something changes.
    task automatic set_digit(input int d, input logic [3:0] nib, input logic v, input logic dp);
        logic [23:0] n;
        logic [5:0]  vv, dd;
        n = m_num; vv = m_valid; dd = m_dp;
        n[4*d +: 4] = nib;
        vv[d] = v;
        dd[d] = dp;
        if (n != m_num || vv != m_valid || dd != m_dp) begin
            exp_q.push_back('{num: n, valid: vv, dp: dd});
            updates_exp++;
        end
        m_num = n; m_valid = vv; m_dp = dd;
    endtask

    // Drive a pair on the pins for exactly n rising edges.
    task automatic hold(input logic [5:0] scan, input logic [7:0] data, input int n);
        @(negedge CLK);
        Scan_Sig = scan;
        SMG_Data = data;
        repeat (n) @(posedge CLK);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_num"},   Number_Data, 24'h0);
        check({tag, "_valid"}, Digit_Valid, 6'h0);
        check({tag, "_dp"},    Digit_DP,    6'h0);
        check({tag, "_upd"},   Update,      1'b0);
        check({tag, "_perr"},  Pattern_Err, 1'b0);
        check({tag, "_ecnt"},  Err_Count,   8'h00);
    endtask

    // Monitor: every Update pulse must match the oldest outstanding expectation.
    initial begin
        snap_t e;
        forever begin
            @(negedge CLK);
            if (RSTn === 1'b1 && Update === 1'b1) begin
                updates_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_update", Update, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("upd_num",   Number_Data, e.num);
                    check("upd_valid", Digit_Valid, e.valid);
                    check("upd_dp",    Digit_DP,    e.dp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] sc;
        logic       dp;

        RSTn = 1'b0; Scan_Sig = 6'h3F; SMG_Data = 8'hFF;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_reset_state("reset");
        RSTn = 1'b1;

        // 1: digit 0 shows "2" for 5 edges
        set_digit(0, 4'h2, 1'b1, 1'b0);
        hold(6'b111110, 8'hA4, 5);
        hold(6'h3F, 8'hFF, 3);

        // 2: only 3 edges -> nothing accepted
        hold(6'b111101, 8'hF9, 3);
        hold(6'h3F, 8'hFF, 3);
        @(negedge CLK);
        check("t2_num",   Number_Data, 24'h000002);
        check("t2_valid", Digit_Valid, 6'b000001);

        // 3: digit 3 "F" with DP, held 20 extra cycles, then an identical re-commit
        set_digit(3, 4'hF, 1'b1, 1'b1);
        hold(6'b110111, 8'h0E, 25);
        hold(6'h3F, 8'hFF, 2);
        hold(6'b110111, 8'h0E, 6);
        hold(6'h3F, 8'hFF, 2);
        @(negedge CLK);
        check("t3_num", Number_Data, 24'h00F002);
        check("t3_dp",  Digit_DP,    6'b001000);

        // 4: digit 1 "1", then blank, then an unknown pattern
        set_digit(1, 4'h1, 1'b1, 1'b0);
        hold(6'b111101, 8'hF9, 5);
        set_digit(1, 4'h1, 1'b0, 1'b0);
        hold(6'b111101, 8'hFF, 5);
        hold(6'b111101, 8'hD5, 5);
        err_events++;
        hold(6'h3F, 8'hFF, 2);
        @(negedge CLK);
        check("t4_valid", Digit_Valid, 6'b001001);
        check("t4_num",   Number_Data, 24'h00F012);
        check("t4_perr",  Pattern_Err, 1'b1);
        check("t4_ecnt",  Err_Count,   exp_errcnt());

        // 5: illegal two-digit scan, then enough error events to saturate the counter
        hold(6'b111100, 8'hA4, 5);
        err_events++;
        hold(6'h3F, 8'hFF, 2);
        @(negedge CLK);
        check("t5_perr",  Pattern_Err, 1'b1);
        check("t5_num",   Number_Data, 24'h00F012);
        check("t5_valid", Digit_Valid, 6'b001001);
        check("t5_ecnt",  Err_Count,   exp_errcnt());
        for (int i = 0; i < 300; i++) begin
            hold(6'b111100, (i % 2 != 0) ? 8'hA4 : 8'hC0, 5);
            err_events++;
        end
        hold(6'h3F, 8'hFF, 2);
        @(negedge CLK);
        check("t5_ecnt_sat", Err_Count,   exp_errcnt());
        check("t5_perr2",    Pattern_Err, 1'b1);

        // 6: all 16 codes across the 6 digits, DP on every third code
        for (int k = 0; k < 16; k++) begin
            dp = (k % 3 == 0);
            sc = ~(6'b000001 << (k % 6));
            set_digit(k % 6, 4'(k), 1'b1, dp);
            hold(sc, {~dp, seg_tab[k]}, 5);
        end
        hold(6'h3F, 8'hFF, 2);
        @(negedge CLK);
        check("t6_num",   Number_Data, 24'hBAFEDC);
        check("t6_valid", Digit_Valid, 6'b111111);
        check("t6_dp",    Digit_DP,    6'b001001);

        // Reset partway through settling: everything clears and nothing commits
        hold(6'b111110, 8'hF9, 2);
        @(negedge CLK);
        RSTn = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check_reset_state("mid_rst");
        RSTn = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        Scan_Sig = 6'h3F; SMG_Data = 8'hFF;
        check("post_rst_valid", Digit_Valid, 6'h0);
        check("post_rst_num",   Number_Data, 24'h0);
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        check("post_rst_valid2", Digit_Valid, 6'h0);

        check("queue_empty",  exp_q.size(), 0);
        check("update_count", updates_seen, updates_exp);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
